gmem_arbiter: RTL and testbench
===============================

// Module: gmem_arbiter
// PURPOSE
//  Shares one global data-memory port between NUM_REQ per-core caches; one transaction in flight.
//  Round-robin arbitration. Each request is held until the memory handshake completes.
//  Sits between the cache array and the data memory; requester and memory sides use the same valid/ready protocol.
// PARAMETERS
//  NUM_REQ    4  number of requesting caches (>=2)
//  ADDR_BITS  8  address width
//  DATA_BITS  8  data width
// PORTS
//  clk               in   1                    clock
//  reset             in   1                    asynchronous, active-high
//  req_read_valid    in   NUM_REQ              per-requester read request, held until read_ready seen
//  req_read_address  in   NUM_REQ*ADDR_BITS    flattened, requester i at [i*ADDR_BITS +: ADDR_BITS]
//  req_read_ready    out  NUM_REQ              read complete, data valid
//  req_read_data     out  NUM_REQ*DATA_BITS    read data, flattened as above
//  req_write_valid   in   NUM_REQ              per-requester write request
//  req_write_address in   NUM_REQ*ADDR_BITS    write address
//  req_write_data    in   NUM_REQ*DATA_BITS    write data
//  req_write_ready   out  NUM_REQ              write accepted by memory
//  mem_read_valid    out  1                    memory read request
//  mem_read_address  out  ADDR_BITS
//  mem_read_ready    in   1                    memory read done; mem_read_data valid this cycle
//  mem_read_data     in   DATA_BITS
//  mem_write_valid   out  1                    memory write request
//  mem_write_address out  ADDR_BITS
//  mem_write_data    out  DATA_BITS
//  mem_write_ready   in   1                    memory write done
//  busy              out  1                    state != IDLE
//  grant_id          out  $clog2(NUM_REQ)      owner of the current/last transaction
// BEHAVIOUR
//  Reset (async):
//   - all outputs 0; state IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//   - Asserting reset mid-transaction aborts it; memory valid drops immediately.
//  All outputs are registered.
//  FSM: IDLE -> MEM_RD | MEM_WR -> RESPOND -> IDLE.
//  IDLE:
//   - Requester i is pending if read_valid[i] | write_valid[i].
//   - Pick the first pending i searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//   - Latch grant_id=i, rr_ptr=i, address and data.
//   - Read has priority over write for the same requester.
//   - Next cycle the memory valid/address/data are high.
//  MEM_RD / MEM_WR:
//   - Hold mem_*_valid and payload stable until mem_*_ready is sampled high.
//   - On read-ready, capture mem_read_data.
//   - Drop mem_*_valid next cycle; enter RESPOND.
//  RESPOND:
//   - Assert req_*_ready[grant_id]; for reads also drive req_read_data[grant_id].
//   - Hold until the requester's corresponding valid is sampled low, then clear ready and go IDLE.
//   - If valid is already low on entry, ready is high exactly one cycle.
//  Non-granted ready bits and data slices: always 0.
//  Latency:
//   - request sampled in cycle 0 -> mem valid cycle 1;
//   - mem ready cycle k -> req ready cycle k+1;
//   - valid low sampled cycle m -> IDLE at m+1, next grant sampled m+1, next mem valid m+2.
//  Fairness: a continuously pending requester is served within NUM_REQ transactions.
//   The pointer advances only on a grant.
//  Request changes while not granted are ignored until arbitration.
//   Address/data changes after the grant are ignored.
//  Simultaneous read+write from one requester: read served, then write in a later grant.
//   That requester's next turn comes after the others per rr_ptr.
// STRUCTURE
//  Shared package gmem_pkg: typedef enum {IDLE,MEM_RD,MEM_WR,RESPOND} gmem_state_t.
//  Sub-module rr_picker (combinational: pending mask + rr_ptr -> grant index, any_pending).
//   Reusable by the cache front-end arbitration.
// TESTING
//  1 Reset, req0 read addr 0x12; memory ready after 3 cycles with 0xA5.
//    -> mem_read_valid high cycles 1-3, addr 0x12; req_read_ready[0]=1 and data 0xA5 from cycle 4.
//  2 All 4 requesters read simultaneously and hold.
//    -> grant order 0,1,2,3; then re-request req0 -> granted after 3.
//  3 req2 write addr 0x40 data 0x3C, memory write_ready after 2 cycles.
//    -> mem_write_* stable for 2 cycles; req_write_ready[2] asserted until req2 drops valid.
//  4 req1 asserts read and write together.
//    -> read issued first; write issued as its own transaction after the read RESPOND.
//  5 Assert reset while in MEM_RD.
//    -> all outputs 0 immediately; after release, req0 is granted first.
//  6 Requester drops valid before RESPOND.
//    -> ready pulses exactly 1 cycle; no other channel's ready or data ever nonzero.

Source files
------------

// File: rtl/gmem_pkg.sv
// Shared types and default sizes for the global data-memory arbiter.
package gmem_pkg;

  localparam int GMEM_NUM_REQ   = 4;
  localparam int GMEM_ADDR_BITS = 8;
  localparam int GMEM_DATA_BITS = 8;

  // Arbiter sequencing: wait for a request, run one memory transaction,
  // then hold the response until the owner drops its valid.
  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    RESPOND
  } gmem_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first pending requester after rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational so other arbiters can reuse it.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any_pending
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset down so the nearest pending requester after rr_ptr wins.
  always_comb begin
    grant       = rr_ptr;
    any_pending = 1'b0;
    cand        = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDW'((int'(rr_ptr) + off) % NUM_REQ);
      if (pending[cand]) begin
        grant       = cand;
        any_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmem_arbiter.sv
// Shares one global data-memory port between NUM_REQ per-core caches.
// One transaction in flight, round-robin grant, all outputs registered.
module gmem_arbiter
  import gmem_pkg::*;
#(
  parameter int NUM_REQ   = GMEM_NUM_REQ,
  parameter int ADDR_BITS = GMEM_ADDR_BITS,
  parameter int DATA_BITS = GMEM_DATA_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_read_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_read_address,
  output logic [NUM_REQ-1:0]           req_read_ready,
  output logic [NUM_REQ*DATA_BITS-1:0] req_read_data,
  input  logic [NUM_REQ-1:0]           req_write_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_write_address,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_write_data,
  output logic [NUM_REQ-1:0]           req_write_ready,
  output logic                         mem_read_valid,
  output logic [ADDR_BITS-1:0]         mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [DATA_BITS-1:0]         mem_read_data,
  output logic                         mem_write_valid,
  output logic [ADDR_BITS-1:0]         mem_write_address,
  output logic [DATA_BITS-1:0]         mem_write_data,
  input  logic                         mem_write_ready,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  gmem_state_t        state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     pick_id;
  logic               any_pending;
  logic               resp_is_read;
  logic [NUM_REQ-1:0] pending;

  assign pending = req_read_valid | req_write_valid;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .pending    (pending),
    .rr_ptr     (rr_ptr),
    .grant      (pick_id),
    .any_pending(any_pending)
  );

  // Main FSM: grant, drive memory until its ready, then respond to the owner until it drops valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= IDW'(NUM_REQ - 1);
      grant_id          <= '0;
      busy              <= 1'b0;
      resp_is_read      <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      req_read_ready    <= '0;
      req_read_data     <= '0;
      req_write_ready   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_pending) begin
            grant_id <= pick_id;
            rr_ptr   <= pick_id;
            busy     <= 1'b1;
            if (req_read_valid[pick_id]) begin
              state            <= MEM_RD;
              mem_read_valid   <= 1'b1;
              mem_read_address <= req_read_address[pick_id*ADDR_BITS +: ADDR_BITS];
            end else begin
              state             <= MEM_WR;
              mem_write_valid   <= 1'b1;
              mem_write_address <= req_write_address[pick_id*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= req_write_data[pick_id*DATA_BITS +: DATA_BITS];
            end
          end
        end
        MEM_RD: begin
          if (mem_read_ready) begin
            mem_read_valid                                 <= 1'b0;
            req_read_ready[grant_id]                       <= 1'b1;
            req_read_data[grant_id*DATA_BITS +: DATA_BITS] <= mem_read_data;
            resp_is_read                                   <= 1'b1;
            state                                          <= RESPOND;
          end
        end
        MEM_WR: begin
          if (mem_write_ready) begin
            mem_write_valid           <= 1'b0;
            req_write_ready[grant_id] <= 1'b1;
            resp_is_read              <= 1'b0;
            state                     <= RESPOND;
          end
        end
        RESPOND: begin
          if (resp_is_read ? !req_read_valid[grant_id] : !req_write_valid[grant_id]) begin
            req_read_ready  <= '0;
            req_read_data   <= '0;
            req_write_ready <= '0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmem_arbiter.sv
// Self-checking bench for gmem_arbiter: directed steps with a scoreboard of
// expected memory transactions, a memory model and a cycle monitor.
module tb_gmem_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_REQ-1:0]           req_read_valid = '0;
  logic [NUM_REQ*ADDR_BITS-1:0] req_read_address = '0;
  logic [NUM_REQ-1:0]           req_read_ready;
  logic [NUM_REQ*DATA_BITS-1:0] req_read_data;
  logic [NUM_REQ-1:0]           req_write_valid = '0;
  logic [NUM_REQ*ADDR_BITS-1:0] req_write_address = '0;
  logic [NUM_REQ*DATA_BITS-1:0] req_write_data = '0;
  logic [NUM_REQ-1:0]           req_write_ready;
  logic                         mem_read_valid;
  logic [ADDR_BITS-1:0]         mem_read_address;
  logic                         mem_read_ready = 1'b0;
  logic [DATA_BITS-1:0]         mem_read_data = 8'hEE;
  logic                         mem_write_valid;
  logic [ADDR_BITS-1:0]         mem_write_address;
  logic [DATA_BITS-1:0]         mem_write_data;
  logic                         mem_write_ready = 1'b0;
  logic                         busy;
  logic [1:0]                   grant_id;

  gmem_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_read_valid   (req_read_valid),
    .req_read_address (req_read_address),
    .req_read_ready   (req_read_ready),
    .req_read_data    (req_read_data),
    .req_write_valid  (req_write_valid),
    .req_write_address(req_write_address),
    .req_write_data   (req_write_data),
    .req_write_ready  (req_write_ready),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       sb[$];
  txn_t       cur;
  bit         cur_valid = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem_model [256];
  int         rd_delay = 1;
  int         wr_delay = 1;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  bit         prev_mem_valid = 1'b0;
  bit         prev_ready = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and record the memory transaction it should produce.
  task automatic applyStimulus(input int id, input bit is_write, input logic [7:0] addr, input logic [7:0] data);
    txn_t t;
    t.id       = id;
    t.is_write = is_write;
    t.addr     = addr;
    if (is_write) begin
      req_write_valid[id]             = 1'b1;
      req_write_address[id*8 +: 8]    = addr;
      req_write_data[id*8 +: 8]       = data;
      t.data                          = data;
    end else begin
      req_read_valid[id]              = 1'b1;
      req_read_address[id*8 +: 8]     = addr;
      t.data                          = mem_model[addr];
    end
    sb.push_back(t);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({mem_read_valid, mem_write_valid, busy, grant_id,
                                    req_read_ready, req_write_ready}), 64'(0));
    checkOutput({tag, "_rdata"}, 64'(req_read_data), 64'(0));
    checkOutput({tag, "_mem_bus"}, 64'({mem_read_address, mem_write_address, mem_write_data}), 64'(0));
  endtask

  // Requester model: drop a valid once its ready is seen; optionally re-request on port 0.
  task automatic runUntilIdle(input int budget, input bit rerequest0, input logic [7:0] readdr);
    bit done = 1'b0;
    bit raise_next = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      waitCycle();
      if (raise_next) begin
        req_read_valid[0]      = 1'b1;
        req_read_address[7:0]  = readdr;
        raise_next             = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_read_ready[i] && req_read_valid[i]) begin
          req_read_valid[i] = 1'b0;
          if (i == 0 && rerequest0) begin
            rerequest0 = 1'b0;
            raise_next = 1'b1;
          end
        end
        if (req_write_ready[i] && req_write_valid[i]) req_write_valid[i] = 1'b0;
      end
      done = (req_read_valid == '0) && (req_write_valid == '0) && !busy && !raise_next;
    end
    checkOutput("run_complete", 64'(done), 64'(1));
    checkOutput("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  // Memory model: assert ready after the programmed number of valid cycles.
  always @(posedge clk) begin
    #1;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'hEE;
    if (mem_read_valid) begin
      rd_cnt++;
      if (rd_cnt == rd_delay) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem_model[mem_read_address];
      end
    end else begin
      rd_cnt = 0;
    end
    if (mem_write_valid) begin
      wr_cnt++;
      if (wr_cnt == wr_delay) begin
        mem_write_ready              = 1'b1;
        mem_model[mem_write_address] = mem_write_data;
      end
    end else begin
      wr_cnt = 0;
    end
  end

  // Monitor: match each new memory transaction and each response against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_mem_valid = 1'b0;
      prev_ready     = 1'b0;
    end else begin
      if ((mem_read_valid || mem_write_valid) && !prev_mem_valid) begin
        checkOutput("txn_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          cur       = sb.pop_front();
          cur_valid = 1'b1;
          checkOutput("grant_id", 64'(grant_id), 64'(cur.id));
          checkOutput("txn_kind", 64'(mem_write_valid), 64'(cur.is_write));
          checkOutput("one_mem_valid", 64'(mem_read_valid & mem_write_valid), 64'(0));
        end
      end
      if (cur_valid && (mem_read_valid || mem_write_valid)) begin
        checkOutput("mem_addr", 64'(cur.is_write ? mem_write_address : mem_read_address), 64'(cur.addr));
        if (cur.is_write) checkOutput("mem_wdata", 64'(mem_write_data), 64'(cur.data));
      end
      if (cur_valid && ((|req_read_ready) || (|req_write_ready)) && !prev_ready) begin
        checkOutput("rd_ready_vec", 64'(req_read_ready), cur.is_write ? 64'(0) : (64'(1) << cur.id));
        checkOutput("wr_ready_vec", 64'(req_write_ready), cur.is_write ? (64'(1) << cur.id) : 64'(0));
      end
      if (cur_valid) begin
        checkOutput("rd_data_bus", 64'(req_read_data),
                    ((|req_read_ready) && !cur.is_write) ? (64'(cur.data) << (8 * cur.id)) : 64'(0));
        checkOutput("stray_ready", 64'((req_read_ready | req_write_ready) & ~(4'(1) << cur.id)), 64'(0));
      end
      prev_mem_valid = mem_read_valid || mem_write_valid;
      prev_ready     = (|req_read_ready) || (|req_write_ready);
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) mem_model[a] = 8'(a * 37 + 11);

    // Reset state
    waitCycle();
    waitCycle();
    checkAllZero("reset_state");
    #2 reset = 1'b0;

    // Test 1: single read with exact latency; address change after grant is ignored
    $display("[TB] test 1: req0 read 0x12");
    waitCycle();
    mem_model[8'h12] = 8'hA5;
    rd_delay = 3;
    applyStimulus(0, 1'b0, 8'h12, 8'h00);
    waitCycle();
    checkOutput("t1_rd_valid_c1", 64'(mem_read_valid), 64'(1));
    checkOutput("t1_busy_c1", 64'(busy), 64'(1));
    req_read_address[7:0] = 8'h77;
    waitCycle();
    checkOutput("t1_rd_valid_c2", 64'(mem_read_valid), 64'(1));
    checkOutput("t1_ready_c2", 64'(req_read_ready), 64'(0));
    waitCycle();
    checkOutput("t1_rd_valid_c3", 64'(mem_read_valid), 64'(1));
    waitCycle();
    checkOutput("t1_rd_valid_c4", 64'(mem_read_valid), 64'(0));
    checkOutput("t1_ready_c4", 64'(req_read_ready), 64'(4'b0001));
    checkOutput("t1_data_c4", 64'(req_read_data[7:0]), 64'(8'hA5));
    req_read_valid[0] = 1'b0;
    waitCycle();
    checkOutput("t1_ready_c5", 64'(req_read_ready), 64'(0));
    checkOutput("t1_busy_c5", 64'(busy), 64'(0));
    waitCycle();

    // Test 3: write with two-cycle memory latency, ready held until valid drops
    $display("[TB] test 3: req2 write 0x40");
    wr_delay = 2;
    applyStimulus(2, 1'b1, 8'h40, 8'h3C);
    waitCycle();
    checkOutput("t3_wr_valid_c1", 64'(mem_write_valid), 64'(1));
    waitCycle();
    checkOutput("t3_wr_valid_c2", 64'(mem_write_valid), 64'(1));
    waitCycle();
    checkOutput("t3_wr_valid_c3", 64'(mem_write_valid), 64'(0));
    checkOutput("t3_ready_c3", 64'(req_write_ready), 64'(4'b0100));
    waitCycle();
    checkOutput("t3_ready_c4", 64'(req_write_ready), 64'(4'b0100));
    waitCycle();
    checkOutput("t3_ready_c5", 64'(req_write_ready), 64'(4'b0100));
    req_write_valid[2] = 1'b0;
    waitCycle();
    checkOutput("t3_ready_c6", 64'(req_write_ready), 64'(0));
    checkOutput("t3_busy_c6", 64'(busy), 64'(0));
    checkOutput("t3_mem_written", 64'(mem_model[8'h40]), 64'(8'h3C));

    // Test 4: req1 read+write with req2 read; pointer at 2 gives 1R, 2R, 1W
    $display("[TB] test 4: req1 read and write together");
    rd_delay = 1;
    wr_delay = 1;
    applyStimulus(1, 1'b0, 8'h21, 8'h00);
    applyStimulus(2, 1'b0, 8'h23, 8'h00);
    applyStimulus(1, 1'b1, 8'h22, 8'h99);
    runUntilIdle(200, 1'b0, 8'h00);
    checkOutput("t4_mem_written", 64'(mem_model[8'h22]), 64'(8'h99));

    // Test 2: fresh reset, all four read; req0 re-requests and is served after 3
    $display("[TB] test 2: four simultaneous reads");
    reset = 1'b1;
    waitCycle();
    #2 reset = 1'b0;
    rd_delay = 2;
    applyStimulus(0, 1'b0, 8'h50, 8'h00);
    applyStimulus(1, 1'b0, 8'h51, 8'h00);
    applyStimulus(2, 1'b0, 8'h52, 8'h00);
    applyStimulus(3, 1'b0, 8'h53, 8'h00);
    sb.push_back('{id: 0, is_write: 1'b0, addr: 8'h55, data: mem_model[8'h55]});
    runUntilIdle(300, 1'b1, 8'h55);

    // Test 5: reset while in MEM_RD aborts; after release req0 wins over req3
    $display("[TB] test 5: reset during memory read");
    rd_delay = 10;
    applyStimulus(2, 1'b0, 8'h60, 8'h00);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("t5_in_mem_rd", 64'(mem_read_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    checkAllZero("t5_reset_now");
    sb.delete();
    cur_valid = 1'b0;
    req_read_valid[2] = 1'b0;
    rd_delay = 1;
    applyStimulus(0, 1'b0, 8'h62, 8'h00);
    applyStimulus(3, 1'b0, 8'h61, 8'h00);
    waitCycle();
    checkAllZero("t5_reset_held");
    #2 reset = 1'b0;
    runUntilIdle(200, 1'b0, 8'h00);

    // Test 6: requester drops valid before the response arrives
    $display("[TB] test 6: early valid drop");
    rd_delay = 2;
    applyStimulus(1, 1'b0, 8'h33, 8'h00);
    waitCycle();
    checkOutput("t6_rd_valid_c1", 64'(mem_read_valid), 64'(1));
    req_read_valid[1] = 1'b0;
    waitCycle();
    checkOutput("t6_ready_c2", 64'(req_read_ready), 64'(0));
    waitCycle();
    checkOutput("t6_ready_c3", 64'(req_read_ready), 64'(4'b0010));
    checkOutput("t6_data_c3", 64'(req_read_data), 64'(mem_model[8'h33]) << 8);
    waitCycle();
    checkOutput("t6_ready_c4", 64'(req_read_ready), 64'(0));
    checkOutput("t6_data_c4", 64'(req_read_data), 64'(0));
    checkOutput("t6_busy_c4", 64'(busy), 64'(0));
    waitCycle();
    waitCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
